// File: rtl/joy_scan_pkg.sv
// Shared types and constants for the serial joystick scanner.
// Includes the scan state encoding and the parameter range check.
package joy_scan_pkg;

    localparam int JOY_W = 16;

    // The enum literals carry an ST_ prefix so they cannot collide with the GAP parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_GAP
    } scan_state_t;

    function automatic bit joy_params_ok(input int players, input int bits, input int clk_div,
                                         input int gap, input int debounce);
        return (players >= 1) && (players <= 4) && (bits >= 1) && (bits <= JOY_W) &&
               (clk_div >= 2) && (gap >= 1) && (debounce >= 1) && (debounce <= 15);
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit debounce filter. The output bit follows a committed frame only after
// DEBOUNCE consecutive disagreeing frames. This module is used only when JOY_DEBOUNCE_EN is defined.
module joy_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic strobe,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

    logic [3:0] agree_cnt_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dout          <= 1'b0;
            agree_cnt_reg <= 4'd0;
        end else if (strobe) begin
            if (din == dout) begin
                agree_cnt_reg <= 4'd0;
            end else if (agree_cnt_reg + 4'd1 == DB_LIMIT) begin
                dout          <= din;
                agree_cnt_reg <= 4'd0;
            end else begin
                agree_cnt_reg <= agree_cnt_reg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/joy_serial_scan.sv
// Serial joystick scanner. It drives the latch and shift clock and deserialises PLAYERS x BITS buttons.
// Define JOY_DEBOUNCE_EN to filter every output bit through joy_debounce.
module joy_serial_scan
    import joy_scan_pkg::*;
#(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 24,
    parameter int GAP      = 64,
    parameter int DEBOUNCE = 2
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       joy_data,
    output logic                       joy_clk,
    output logic                       joy_load,
    output logic [JOY_W*PLAYERS-1:0]   joystick,
    output logic                       valid
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int OUT_W = JOY_W * PLAYERS;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int POS_W = $clog2(OUT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [6:0]       IDX_LAST = 7'(TOTAL - 1);
    localparam logic [3:0]       BIT_LAST = 4'(BITS - 1);
    localparam logic [POS_W-1:0] POS_SKIP = POS_W'(JOY_W - BITS + 1);

    if (!joy_params_ok(PLAYERS, BITS, CLK_DIV, GAP, DEBOUNCE)) begin : g_bad_params
        $error("joy_serial_scan: parameter out of range");
    end

    scan_state_t      state_reg;
    logic [DIV_W-1:0] div_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [6:0]       idx_reg;
    logic [3:0]       bit_reg;
    logic [POS_W-1:0] pos_reg;
    logic [OUT_W-1:0] frame_reg;
    logic [OUT_W-1:0] frame_next;
    logic             tick;
    logic             commit_now;

    assign tick       = (div_reg == DIV_LAST);
    assign commit_now = tick && enable && (state_reg == ST_SHIFT_HI) && (idx_reg == IDX_LAST);

    // The current sample is merged in combinationally so the final bit lands in the same commit.
    always_comb begin
        frame_next          = frame_reg;
        frame_next[pos_reg] = ~joy_data;
    end

    // While parked, the divider is held at 0. Enabling the scanner then gives a fixed latch latency.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_reg <= '0;
        end else if ((!enable && state_reg == ST_IDLE) || tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            gap_reg   <= '0;
            idx_reg   <= '0;
            bit_reg   <= '0;
            pos_reg   <= '0;
            frame_reg <= '0;
            joy_clk   <= 1'b1;
            joy_load  <= 1'b1;
        end else if (tick) begin
            if (state_reg != ST_IDLE && !enable) begin
                state_reg <= ST_IDLE;
                joy_clk   <= 1'b1;
                joy_load  <= 1'b1;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        if (enable) begin
                            state_reg <= ST_LATCH;
                            joy_load  <= 1'b0;
                            idx_reg   <= '0;
                            bit_reg   <= '0;
                            pos_reg   <= '0;
                            frame_reg <= '0;
                        end
                    end
                    ST_LATCH: begin
                        state_reg <= ST_SHIFT_LO;
                        joy_load  <= 1'b1;
                        joy_clk   <= 1'b0;
                    end
                    ST_SHIFT_LO: begin
                        state_reg <= ST_SHIFT_HI;
                        joy_clk   <= 1'b1;
                    end
                    ST_SHIFT_HI: begin
                        frame_reg <= frame_next;
                        idx_reg   <= idx_reg + 7'd1;
                        // After a player's last bit, the position pointer jumps to the next 16-bit word.
                        if (bit_reg == BIT_LAST) begin
                            bit_reg <= '0;
                            pos_reg <= pos_reg + POS_SKIP;
                        end else begin
                            bit_reg <= bit_reg + 4'd1;
                            pos_reg <= pos_reg + POS_W'(1);
                        end
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= ST_GAP;
                            gap_reg   <= '0;
                        end else begin
                            state_reg <= ST_SHIFT_LO;
                            joy_clk   <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (gap_reg == GAP_LAST) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_reg <= gap_reg + GAP_W'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid <= 1'b0;
        end else begin
            valid <= commit_now;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_db
        joy_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .clk_sys (clk_sys),
            .reset   (reset),
            .strobe  (commit_now),
            .din     (frame_next[gi]),
            .dout    (joystick[gi])
        );
    end
`else
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joystick <= '0;
        end else if (commit_now) begin
            joystick <= frame_next;
        end
    end
`endif

endmodule

// File: tb/tb_joy_serial_scan.sv
// Scoreboard bench for joy_serial_scan. An adapter model pushes the expected frame on every latch,
// and a monitor pops and compares that frame whenever valid pulses.
`timescale 1ns/1ps
module tb_joy_serial_scan;

    localparam int PLAYERS   = 2;
    localparam int BITS      = 12;
    localparam int CLK_DIV   = 4;
    localparam int GAP       = 8;
    localparam int DEBOUNCE  = 2;
    localparam int FRAME_CYC = (1 + 2 * PLAYERS * BITS + GAP + 1) * CLK_DIV;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [31:0] joystick;
    logic        valid;

    joy_serial_scan #(
        .PLAYERS  (PLAYERS),
        .BITS     (BITS),
        .CLK_DIV  (CLK_DIV),
        .GAP      (GAP),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .enable   (enable),
        .joy_data (joy_data),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joystick (joystick),
        .valid    (valid)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Adapter model. It captures raw active-low patterns on the latch, and each joy_clk rise presents the next bit.
    logic [11:0] pat0 = 12'hFFF;
    logic [11:0] pat1 = 12'hFFF;
    logic [23:0] shift_data = '1;
    int          ptr = -1;
    logic [31:0] sb[$];

    always @(negedge joy_load) begin
        shift_data = {pat1, pat0};
        ptr = -1;
        sb.push_back({4'h0, ~pat1, 4'h0, ~pat0});
    end
    always @(posedge joy_clk) ptr = ptr + 1;
    assign joy_data = (ptr >= 0 && ptr < 24) ? shift_data[ptr] : 1'b1;

    // Monitor with the reference output model.
    logic        rst_seen = 1'b1;
    logic [31:0] hold_exp = '0;
    int          dbc[32];
    int          last_v = -1;
    bit          spacing_en = 0;
    int          valid_cnt = 0;

    always @(posedge clk_sys) rst_seen <= reset;

    initial begin
        logic        prev_valid;
        logic [31:0] raw;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (rst_seen) begin
                hold_exp = '0;
                foreach (dbc[i]) dbc[i] = 0;
                sb.delete();
                last_v = -1;
                prev_valid = 1'b0;
            end else begin
                if (valid) begin
                    valid_cnt++;
                    check("valid_single_cycle", {31'b0, prev_valid}, 32'h0);
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_valid: valid with no pending frame (cycle %0d)", cyc);
                    end else begin
                        raw = sb.pop_front();
`ifdef JOY_DEBOUNCE_EN
                        for (int i = 0; i < 32; i++) begin
                            if (raw[i] != hold_exp[i]) begin
                                dbc[i]++;
                                if (dbc[i] == DEBOUNCE) begin
                                    hold_exp[i] = raw[i];
                                    dbc[i] = 0;
                                end
                            end else begin
                                dbc[i] = 0;
                            end
                        end
`else
                        hold_exp = raw;
`endif
                        check("joystick_commit", joystick, hold_exp);
                    end
                    if (spacing_en && last_v >= 0) check("valid_spacing", cyc - last_v, FRAME_CYC);
                    last_v = cyc;
                end else begin
                    check("joystick_hold", joystick, hold_exp);
                end
                prev_valid = valid;
            end
        end
    end

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
            @(negedge clk_sys);
            if (valid) seen = 1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s: timeout waiting for valid", name);
        end
    endtask

    task automatic wait_load_fall(input string name);
        logic prev = joy_load;
        bit   seen = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
            @(negedge clk_sys);
            if (prev && !joy_load) seen = 1;
            prev = joy_load;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s: timeout waiting for joy_load fall", name);
        end
    endtask

    task automatic wait_clk_rises(input string name, input int n);
        logic prev = joy_clk;
        int   cnt  = 0;
        for (int i = 0; i < 2 * FRAME_CYC && cnt < n; i++) begin
            @(negedge clk_sys);
            if (!prev && joy_clk) cnt++;
            prev = joy_clk;
        end
        if (cnt < n) begin
            n_total++;
            $display("FAIL %s: saw %0d joy_clk rises, required %0d", name, cnt, n);
        end
    endtask

    initial begin
        int   t0;
        int   v0;
        bit   clk_fell;
        bit   seen;

        // Reset state.
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_joy_clk", {31'b0, joy_clk}, 32'h1);
        check("reset_joy_load", {31'b0, joy_load}, 32'h1);
        check("reset_joystick", joystick, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);

        // First latch latency after enable.
        pat0 = 12'hFFE;
        pat1 = 12'hFFF;
        reset = 1'b0;
        @(negedge clk_sys);
        enable = 1'b1;
        t0 = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (!joy_load) seen = 1;
        end
        check("load_latency", cyc - t0, 32'd4);
        spacing_en = 1;

        wait_valid("first_frame");
`ifndef JOY_DEBOUNCE_EN
        check("first_frame_word", joystick, 32'h0000_0001);
`endif
        pat0 = 12'hFFF;
        pat1 = 12'h7FF;
        wait_valid("p1_bit11_frame");
`ifndef JOY_DEBOUNCE_EN
        check("p1_bit11_upper", {27'b0, joystick[31:27]}, 32'h1);
`endif

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            pat0 = 12'($urandom);
            pat1 = 12'($urandom);
            wait_valid("random_frame");
        end

        // A single-frame glitch on player 0 bit 4, followed by two consecutive presses.
        pat0 = 12'hFFF;
        pat1 = 12'hFFF;
        repeat (3) wait_valid("settle_frame");
        pat0 = 12'hFEF;
        wait_valid("glitch_frame");
`ifdef JOY_DEBOUNCE_EN
        check("glitch_ignored", {31'b0, joystick[4]}, 32'h0);
`endif
        pat0 = 12'hFFF;
        wait_valid("after_glitch");
`ifdef JOY_DEBOUNCE_EN
        check("glitch_released", {31'b0, joystick[4]}, 32'h0);
`endif
        pat0 = 12'hFEF;
        wait_valid("press_1");
`ifdef JOY_DEBOUNCE_EN
        check("press_first_frame", {31'b0, joystick[4]}, 32'h0);
`endif
        wait_valid("press_2");
        check("press_second_frame", {31'b0, joystick[4]}, 32'h1);

        // A reset pulse during the 10th SHIFT_HI.
        spacing_en = 0;
        wait_load_fall("reset_test_latch");
        wait_clk_rises("reset_test_rises", 10);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midreset_joystick", joystick, 32'h0);
        check("midreset_valid", {31'b0, valid}, 32'h0);
        check("midreset_lines", {30'b0, joy_clk, joy_load}, 32'h3);
        reset = 1'b0;
        clk_fell = 0;
        seen = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
            @(negedge clk_sys);
            if (!joy_clk) clk_fell = 1;
            if (!joy_load) seen = 1;
        end
        check("restart_with_latch", {30'b0, seen, clk_fell}, 32'h2);

        // Establish joystick = 1, then drop enable in the middle of a frame.
        pat0 = 12'hFFE;
        pat1 = 12'hFFF;
        repeat (4) wait_valid("pre_abort_frame");
        check("pre_abort_word", joystick, 32'h0000_0001);
        wait_load_fall("abort_latch");
        wait_clk_rises("abort_rises", 5);
        @(negedge clk_sys);
        enable = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("abort_lines_idle", {30'b0, joy_clk, joy_load}, 32'h3);
        sb.delete();
        v0 = valid_cnt;
        repeat (3 * FRAME_CYC) @(negedge clk_sys);
        check("abort_joystick_held", joystick, 32'h0000_0001);
        check("abort_no_valid", valid_cnt, v0);
        check("parked_lines", {30'b0, joy_clk, joy_load}, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
